// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP fetch front end.
package yarp_pkg;

  localparam logic [31:0] YARP_PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/yarp_fetch_fifo.sv
// Response buffer between instruction memory and decode.
// Ports: push/wdata write the tail, pop retires the head (rdata),
// flush empties the buffer and takes priority over push and pop;
// empty/full/count report occupancy.
module yarp_fetch_fifo
  import yarp_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/yarp_fetch_ctrl.sv
// YARP instruction-fetch front end: owns the PC, issues credit-limited
// in-order requests to imem, drops responses made stale by a redirect,
// and presents {pc, instr} to decode over valid/ready.
// Ports: redirect_i/redirect_pc_i from execute; imem_req_o/imem_addr_o/
// imem_gnt_i request channel; imem_rvalid_i/imem_rdata_i response channel;
// instr_valid_o/instr_o/instr_pc_o/instr_ready_i to decode; misalign_o.
// Build option: YARP_FETCH_MISALIGN_CHK_EN halts fetch on a misaligned
// redirect and raises a sticky misalign_o; otherwise targets are word-aligned.
module yarp_fetch_ctrl
  import yarp_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic         halted_q, halted_d;

  logic [CW-1:0] outst_next;
  logic [CW:0]   occupancy;
  logic [31:0]   target;
  logic          grant;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_head;

  always_comb begin
    occupancy  = {1'b0, outst_q} + {1'b0, fifo_count};
    imem_req_o = !reset && !redirect_i && (occupancy < DEPTH_C) && !halted_q;
    grant      = imem_req_o && imem_gnt_i;
    outst_next = outst_q + CW'(grant) - CW'(imem_rvalid_i);

`ifdef YARP_FETCH_MISALIGN_CHK_EN
    target   = redirect_pc_i;
    halted_d = halted_q || (redirect_i && (redirect_pc_i[1:0] != 2'b00));
`else
    target   = redirect_pc_i & 32'hFFFF_FFFC;
    halted_d = 1'b0;
`endif

    fifo_pop   = instr_valid_o && instr_ready_i && !redirect_i;
    fifo_push  = imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i &&
                 (!fifo_full || fifo_pop);
    fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata_i};

    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    outst_d    = outst_next;

    if (redirect_i) begin
      pc_d      = target;
      resp_pc_d = target;
      // Every request still in flight after this cycle belongs to the old
      // stream; outst_next already includes any pending drops, so it is the
      // new drop count (keeps drop_cnt <= outst across back-to-back redirects).
      drop_cnt_d = outst_next;
    end else begin
      if (grant)     pc_d      = pc_q + YARP_PC_INCR;
      if (fifo_push) resp_pc_d = resp_pc_q + YARP_PC_INCR;
      if (imem_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      halted_q   <= halted_d;
    end
  end

  yarp_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_i),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : fifo_head.instr;
  assign instr_pc_o    = fifo_empty ? '0 : fifo_head.pc;
  assign misalign_o    = halted_q;

endmodule

// File: tb/tb_yarp_fetch_ctrl.sv
module tb_yarp_fetch_ctrl;

  localparam int unsigned DEPTH = 2;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic        misalign_o;

  always #5 clk = ~clk;

  yarp_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .misalign_o    (misalign_o)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Directed table
  typedef struct {
    logic        rst, rd;
    logic [31:0] rpc;
    logic        g, rv;
    logic [31:0] rva;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rd, input logic [31:0] rpc,
                              input logic g, input logic rv, input logic [31:0] rva,
                              input logic rdy, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.rd = rd; v.rpc = rpc; v.g = g; v.rv = rv; v.rva = rva; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_pc = ep;
    return v;
  endfunction

  // Reference model: each request is tagged with the redirect epoch it was
  // issued in; a response survives only if its epoch is still current.
  typedef struct { logic [31:0] addr; int unsigned ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  req_t        pend[$];
  ent_t        expq[$];
  int unsigned epoch;
  logic [31:0] pc_m;
  bit          halt_m;

  task automatic model_reset();
    pend.delete();
    expq.delete();
    epoch  = 0;
    pc_m   = 32'h0;
    halt_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic g,
                     input logic rvw, input logic rdy);
    logic  rv, req_m;
    req_t  r;
    @(negedge clk);
    rv = rvw && (pend.size() != 0);
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(pend[0].addr) : 32'h0;
    instr_ready_i = rdy;
    req_m = !rd && (pend.size() + expq.size() < DEPTH) && !halt_m;
    #1;
    chk("req", {31'b0, imem_req_o}, {31'b0, req_m});
    if (req_m) chk("addr", imem_addr_o, pc_m);
    chk("valid", {31'b0, instr_valid_o}, {31'b0, expq.size() != 0});
    if (expq.size() != 0) begin
      chk("instr_pc", instr_pc_o, expq[0].pc);
      chk("instr", instr_o, expq[0].instr);
    end
    chk("misalign", {31'b0, misalign_o}, {31'b0, halt_m});
    if (rv) r = pend.pop_front();
    if (rd) begin
      expq.delete();
      epoch++;
      pc_m = MIS_EN ? rpc : (rpc & 32'hFFFF_FFFC);
      if (MIS_EN && (rpc[1:0] != 2'b00)) halt_m = 1'b1;
    end else begin
      if (rdy && expq.size() != 0) void'(expq.pop_front());
      if (rv && r.ep == epoch) expq.push_back('{r.addr, mem_word(r.addr)});
      if (req_m && g) begin
        pend.push_back('{pc_m, epoch});
        pc_m = pc_m + 32'd4;
      end
    end
  endtask

  initial begin
    vec_t tbl[20];
    tbl[0]  = mk(1,0,32'h0,  0,0,32'h0,  0, 0,32'h0,  0,32'h0);
    tbl[1]  = mk(0,0,32'h0,  1,0,32'h0,  1, 1,32'h0,  0,32'h0);
    tbl[2]  = mk(0,0,32'h0,  1,1,32'h0,  1, 1,32'h4,  0,32'h0);
    tbl[3]  = mk(0,0,32'h0,  1,1,32'h4,  1, 0,32'h8,  1,32'h0);
    tbl[4]  = mk(0,0,32'h0,  1,0,32'h0,  1, 1,32'h8,  1,32'h4);
    tbl[5]  = mk(0,0,32'h0,  1,1,32'h8,  0, 1,32'hC,  0,32'h0);
    tbl[6]  = mk(0,0,32'h0,  1,1,32'hC,  0, 0,32'h10, 1,32'h8);
    tbl[7]  = mk(0,0,32'h0,  1,0,32'h0,  0, 0,32'h10, 1,32'h8);
    tbl[8]  = mk(0,0,32'h0,  1,0,32'h0,  1, 0,32'h10, 1,32'h8);
    tbl[9]  = mk(0,1,32'h100,1,0,32'h0,  0, 0,32'h10, 1,32'hC);
    tbl[10] = mk(0,0,32'h0,  0,0,32'h0,  1, 1,32'h100,0,32'h0);
    tbl[11] = mk(0,0,32'h0,  1,0,32'h0,  1, 1,32'h100,0,32'h0);
    tbl[12] = mk(0,0,32'h0,  1,0,32'h0,  1, 1,32'h104,0,32'h0);
    tbl[13] = mk(0,1,32'h200,1,1,32'h100,1, 0,32'h108,0,32'h0);
    tbl[14] = mk(0,0,32'h0,  1,0,32'h0,  1, 1,32'h200,0,32'h0);
    tbl[15] = mk(0,0,32'h0,  1,1,32'h104,1, 0,32'h204,0,32'h0);
    tbl[16] = mk(0,0,32'h0,  1,1,32'h200,1, 1,32'h204,0,32'h0);
    tbl[17] = mk(0,0,32'h0,  1,1,32'h204,1, 0,32'h208,1,32'h200);
    tbl[18] = mk(0,0,32'h0,  0,0,32'h0,  1, 1,32'h208,1,32'h204);
    tbl[19] = mk(0,0,32'h0,  0,0,32'h0,  1, 1,32'h208,0,32'h0);

    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      redirect_i    = tbl[i].rd;
      redirect_pc_i = tbl[i].rpc;
      imem_gnt_i    = tbl[i].g;
      imem_rvalid_i = tbl[i].rv;
      imem_rdata_i  = tbl[i].rv ? mem_word(tbl[i].rva) : 32'h0;
      instr_ready_i = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_req", i), {31'b0, imem_req_o}, {31'b0, tbl[i].e_req});
      chk($sformatf("t%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, tbl[i].e_val});
      chk($sformatf("t%0d_pc", i), instr_pc_o, tbl[i].e_val ? tbl[i].e_pc : 32'h0);
      chk($sformatf("t%0d_instr", i), instr_o, tbl[i].e_val ? mem_word(tbl[i].e_pc) : 32'h0);
      chk($sformatf("t%0d_misalign", i), {31'b0, misalign_o}, 32'h0);
    end

    // Back-to-back redirects with responses in flight
    do_reset();
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // PC wrap
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Misaligned redirect, then reset clears it
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h102, 1'b1, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    do_reset();
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic
    do_reset();
    for (int unsigned n = 0; n < 3000; n++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      cyc(rd, rpc, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
